// File: rtl/muldiv_pkg.sv
// Shared CPU package: ALU and mul/div opcodes,
// mul/div FSM states and small decode helpers.
package muldiv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b1000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SRA  = 4'b1101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_MUL  = 3'b000,
    MD_MULH = 3'b001,
    MD_DIVU = 3'b010,
    MD_REMU = 3'b011,
    MD_DIV  = 3'b100,
    MD_REM  = 3'b101,
    MD_RSV6 = 3'b110,
    MD_RSV7 = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } md_state_e;

  function automatic logic md_is_rsv(
    input logic [2:0] op
  );
    return op[2:1] == 2'b11;
  endfunction

  function automatic logic md_is_mul(
    input logic [2:0] op
  );
    return op[2:1] == 2'b00;
  endfunction

  function automatic logic md_is_div(
    input logic [2:0] op
  );
    return !md_is_mul(op) && !md_is_rsv(op);
  endfunction

  function automatic logic md_is_signed(
    input logic [2:0] op
  );
    return op[2:1] == 2'b10;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or
// restoring shift-subtract divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             div,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] hi_nx,
  output logic [WIDTH-1:0] lo_nx
);

  logic [WIDTH:0]   x;
  logic [WIDTH:0]   y;
  logic [WIDTH:0]   y_eff;
  logic [WIDTH+1:0] full;
  logic             ge;

  // Adder operands: partial product or shifted remainder
  always_comb begin
    x = {1'b0, hi};
    y = '0;
    if (div) begin
      x = {hi, lo[WIDTH-1]};
      y = {1'b0, opnd};
    end else if (lo[0]) begin
      y = {1'b0, opnd};
    end
  end

  assign y_eff = div ? ~y : y;
  assign full  = {1'b0, x} + {1'b0, y_eff}
               + {{(WIDTH+1){1'b0}}, div};
  assign ge    = full[WIDTH+1];

  // Next remainder/quotient or next product halves
  always_comb begin
    if (div) begin
      hi_nx = ge ? full[WIDTH-1:0] : x[WIDTH-1:0];
      lo_nx = {lo[WIDTH-2:0], ge};
    end else begin
      hi_nx = full[WIDTH:1];
      lo_nx = {full[0], lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential multiply/divide unit: one bit per
// cycle, sign fix-up cycle, valid/ready result.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din_a,
  input  logic [WIDTH-1:0] din_b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             vout,
  output logic             dz
);

  localparam logic [WIDTH-1:0] MIN_NEG =
    {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNTW-1:0] CNT_LOAD =
    CNTW'(WIDTH - 1);

  md_state_e        state;
  logic [CNTW-1:0]  cnt;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opnd;
  md_op_e           op_q;
  logic             sign_a;
  logic             sign_b;
  logic             ovf;

  logic             is_sgn;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             is_rsv;
  logic             is_zdiv;
  logic             is_ovf;
  logic [WIDTH-1:0] zdiv_res;

  logic [WIDTH-1:0] hi_nx;
  logic [WIDTH-1:0] lo_nx;
  logic [WIDTH-1:0] res_d;
  logic             res_v;

  assign in_ready = (state == S_IDLE);

  assign is_sgn  = md_is_signed(op);
  assign sa      = is_sgn & din_a[WIDTH-1];
  assign sb      = is_sgn & din_b[WIDTH-1];
  assign a_mag   = sa ? -din_a : din_a;
  assign b_mag   = sb ? -din_b : din_b;
  assign is_rsv  = md_is_rsv(op);
  assign is_zdiv = md_is_div(op) && (din_b == '0);
  assign is_ovf  = (op == MD_DIV)
                && (din_a == MIN_NEG)
                && (din_b == '1);
  assign zdiv_res = (op == MD_DIVU || op == MD_DIV)
                  ? '1 : din_a;

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .div   (md_is_div(op_q)),
    .hi    (hi),
    .lo    (lo),
    .opnd  (opnd),
    .hi_nx (hi_nx),
    .lo_nx (lo_nx)
  );

  // Result select and sign correction for FIX
  always_comb begin
    res_d = lo;
    res_v = 1'b0;
    case (op_q)
      MD_MUL: begin
        res_d = lo;
        res_v = |hi;
      end
      MD_MULH: res_d = hi;
      MD_DIVU: res_d = lo;
      MD_REMU: res_d = hi;
      MD_DIV: begin
        res_d = (sign_a ^ sign_b) ? -lo : lo;
        res_v = ovf;
      end
      MD_REM:  res_d = sign_a ? -hi : hi;
      default: res_d = '0;
    endcase
  end

  // Control FSM, iteration datapath, result regs
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state     <= S_IDLE;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      opnd      <= '0;
      op_q      <= MD_MUL;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      dout      <= '0;
      vout      <= 1'b0;
      dz        <= 1'b0;
    end else if (flush) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            unique case (1'b1)
              is_rsv: begin
                state     <= S_DONE;
                out_valid <= 1'b1;
                dout      <= '0;
                vout      <= 1'b0;
                dz        <= 1'b1;
              end
              is_zdiv: begin
                state     <= S_DONE;
                out_valid <= 1'b1;
                dout      <= zdiv_res;
                vout      <= 1'b0;
                dz        <= 1'b1;
              end
              default: begin
                state  <= S_RUN;
                cnt    <= CNT_LOAD;
                op_q   <= md_op_e'(op);
                hi     <= '0;
                sign_a <= sa;
                sign_b <= sb;
                ovf    <= is_ovf;
                if (md_is_mul(op)) begin
                  lo   <= din_b;
                  opnd <= din_a;
                end else begin
                  lo   <= a_mag;
                  opnd <= b_mag;
                end
              end
            endcase
          end
        end
        S_RUN: begin
          hi  <= hi_nx;
          lo  <= lo_nx;
          cnt <= cnt - CNTW'(1);
          if (cnt == '0) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          state     <= S_DONE;
          out_valid <= 1'b1;
          dout      <= res_d;
          vout      <= res_v;
          dz        <= 1'b0;
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: vector table
// plus flush, hold, reset and handshake sequences.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_b = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] din_a = '0;
  logic [W-1:0] din_b = '0;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] dout;
  logic         vout;
  logic         dz;

  int n_cmp = 0;
  int n_bad = 0;
  int vrise = 0;
  logic ov_d = 1'b0;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_b   (reset_b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .din_a     (din_a),
    .din_b     (din_b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .vout      (vout),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ov_d <= out_valid;
    if (out_valid && !ov_d) vrise++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=running req=done");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         v;
    logic         z;
    int           lat;
    string        nm;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%h req=%h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] o,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic [W-1:0] ed,
                        input logic ev,
                        input logic ez,
                        input int el,
                        input bit rel,
                        input string nm);
    int n;
    @(negedge clk);
    op = o; din_a = a; din_b = b; in_valid = 1'b1;
    chk({nm, ".in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom);
    din_a = $urandom;
    din_b = $urandom;
    n = 1;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, ".lat"}, 64'(n), 64'(el));
    chk({nm, ".dout"}, 64'(dout), 64'(ed));
    chk({nm, ".vout"}, 64'(vout), 64'(ev));
    chk({nm, ".dz"}, 64'(dz), 64'(ez));
    if (rel) begin
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      chk({nm, ".idle"}, 64'(in_ready), 64'd1);
      chk({nm, ".ovlo"}, 64'(out_valid), 64'd0);
    end
  endtask

  initial begin
    int v0;
    vt.push_back('{MD_MUL, 32'h0001_0000, 32'h0001_0000,
                   32'h0, 1'b1, 1'b0, 34, "mul_ovf"});
    vt.push_back('{MD_MULH, 32'h0001_0000, 32'h0001_0000,
                   32'h1, 1'b0, 1'b0, 34, "mulh"});
    vt.push_back('{MD_DIV, 32'hFFFF_FFF9, 32'd2,
                   32'hFFFF_FFFD, 1'b0, 1'b0, 34, "div_m7_2"});
    vt.push_back('{MD_REM, 32'hFFFF_FFF9, 32'd2,
                   32'hFFFF_FFFF, 1'b0, 1'b0, 34, "rem_m7_2"});
    vt.push_back('{MD_DIVU, 32'd100, 32'd0,
                   32'hFFFF_FFFF, 1'b0, 1'b1, 1, "divu_z"});
    vt.push_back('{MD_REMU, 32'd100, 32'd0,
                   32'd100, 1'b0, 1'b1, 1, "remu_z"});
    vt.push_back('{MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
                   32'h8000_0000, 1'b1, 1'b0, 34, "div_ovf"});
    vt.push_back('{MD_REM, 32'h8000_0000, 32'hFFFF_FFFF,
                   32'h0, 1'b0, 1'b0, 34, "rem_ovf"});
    vt.push_back('{MD_MUL, 32'd7, 32'd6,
                   32'd42, 1'b0, 1'b0, 34, "mul_7_6"});
    vt.push_back('{MD_DIVU, 32'd100, 32'd7,
                   32'd14, 1'b0, 1'b0, 34, "divu_100_7"});
    vt.push_back('{MD_REMU, 32'd100, 32'd7,
                   32'd2, 1'b0, 1'b0, 34, "remu_100_7"});
    vt.push_back('{MD_RSV6, 32'd5, 32'd3,
                   32'h0, 1'b0, 1'b1, 1, "rsv6"});
    vt.push_back('{MD_RSV7, 32'd5, 32'd0,
                   32'h0, 1'b0, 1'b1, 1, "rsv7"});
    vt.push_back('{MD_DIV, 32'd7, 32'hFFFF_FFFE,
                   32'hFFFF_FFFD, 1'b0, 1'b0, 34, "div_7_m2"});
    vt.push_back('{MD_REM, 32'd7, 32'hFFFF_FFFE,
                   32'd1, 1'b0, 1'b0, 34, "rem_7_m2"});
    vt.push_back('{MD_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                   32'hFFFF_FFFE, 1'b0, 1'b0, 34, "mulh_max"});
    vt.push_back('{MD_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                   32'h1, 1'b1, 1'b0, 34, "mul_max"});
    vt.push_back('{MD_DIVU, 32'hFFFF_FFFF, 32'd1,
                   32'hFFFF_FFFF, 1'b0, 1'b0, 34, "divu_max_1"});
    vt.push_back('{MD_DIV, 32'hFFFF_FFFB, 32'd0,
                   32'hFFFF_FFFF, 1'b0, 1'b1, 1, "div_z"});
    vt.push_back('{MD_REM, 32'hFFFF_FFFB, 32'd0,
                   32'hFFFF_FFFB, 1'b0, 1'b1, 1, "rem_z"});

    // reset state
    #12;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.dout", 64'(dout), 64'd0);
    chk("rst.vout", 64'(vout), 64'd0);
    chk("rst.dz", 64'(dz), 64'd0);
    @(negedge clk); reset_b = 1'b1;
    @(posedge clk); #1;
    chk("rst.in_ready", 64'(in_ready), 64'd1);

    foreach (vt[i]) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].d,
             vt[i].v, vt[i].z, vt[i].lat, 1'b1,
             vt[i].nm);
    end

    // flush in DONE beats out_ready, keeps result
    run_op(MD_MUL, 32'd3, 32'd5, 32'd15, 1'b0, 1'b0,
           34, 1'b0, "mul_3_5");
    @(negedge clk);
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    op = MD_MUL; din_a = 32'd2; din_b = 32'd2;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    chk("dflush.out_valid", 64'(out_valid), 64'd0);
    chk("dflush.in_ready", 64'(in_ready), 64'd1);
    chk("dflush.dout", 64'(dout), 64'd15);

    // flush mid-RUN, then immediate DIVU 9/3
    @(negedge clk);
    op = MD_DIVU; din_a = 32'd1000; din_b = 32'd3;
    in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1;
    op = MD_MUL; din_a = 32'd9; din_b = 32'd9;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("rflush.out_valid", 64'(out_valid), 64'd0);
    chk("rflush.in_ready", 64'(in_ready), 64'd1);
    chk("rflush.dout", 64'(dout), 64'd15);
    v0 = vrise;
    run_op(MD_DIVU, 32'd9, 32'd3, 32'd3, 1'b0, 1'b0,
           34, 1'b0, "divu_9_3");
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("hold.dout", 64'(dout), 64'd3);
      chk("hold.in_ready", 64'(in_ready), 64'd0);
      chk("hold.out_valid", 64'(out_valid), 64'd1);
    end
    chk("flush.vrise", 64'(vrise - v0), 64'd1);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;

    // no accept in the out_ready cycle
    run_op(MD_MUL, 32'd4, 32'd4, 32'd16, 1'b0, 1'b0,
           34, 1'b0, "mul_4_4");
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    op = MD_MUL; din_a = 32'd5; din_b = 32'd5;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    chk("ordy.in_ready", 64'(in_ready), 64'd1);
    chk("ordy.out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("ordy.no_accept", 64'(in_ready), 64'd1);

    // async reset mid-RUN
    @(negedge clk);
    op = MD_MUL; din_a = 32'd11; din_b = 32'd13;
    in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); reset_b = 1'b0;
    #1;
    chk("mrst.out_valid", 64'(out_valid), 64'd0);
    chk("mrst.dout", 64'(dout), 64'd0);
    chk("mrst.vout", 64'(vout), 64'd0);
    chk("mrst.dz", 64'(dz), 64'd0);
    v0 = vrise;
    @(negedge clk); reset_b = 1'b1;
    @(posedge clk); #1;
    chk("mrst.in_ready", 64'(in_ready), 64'd1);
    repeat (40) @(posedge clk);
    #1;
    chk("mrst.vrise", 64'(vrise - v0), 64'd0);
    chk("mrst.idle", 64'(in_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; legal values 8..64, even.
REQ-002 Parameter CNTW, default $clog2(WIDTH)+1, iteration counter width.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 reset_b  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  operation request.
REQ-006 in_ready  out  1  high when a request can be accepted (state IDLE).
REQ-007 op  in  3  operation code, sampled on accept.
REQ-008 din_a  in  WIDTH  multiplicand / dividend, sampled on accept.
REQ-009 din_b  in  WIDTH  multiplier / divisor, sampled on accept.
REQ-010 flush  in  1  synchronous abort of any operation in progress.
REQ-011 out_valid  out  1  result available.
REQ-012 out_ready  in  1  consumer accepts result.
REQ-013 dout  out  WIDTH  result.
REQ-014 vout  out  1  overflow flag for the result.
REQ-015 dz  out  1  divide-by-zero or reserved-op flag.

Function
REQ-016 Ops: 000 MUL (low WIDTH of unsigned product), 001 MULH (high WIDTH of unsigned product), 010 DIVU, 011 REMU, 100 DIV (signed quotient), 101 REM (signed remainder, sign of dividend); 110/111 reserved.
REQ-017 States IDLE, RUN, FIX, DONE; accept = in_valid & in_ready; in_ready = (state==IDLE).
REQ-018 IDLE->RUN on accept of MUL/MULH/DIVx/REMx with nonzero divisor (divisor nonzero irrelevant for MUL/MULH); operands latched, signed ops latch magnitudes plus sign bits; counter loaded WIDTH-1.
REQ-019 RUN: one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle; exactly WIDTH cycles; RUN->FIX when counter==0.
REQ-020 FIX: one cycle applying sign correction (negate quotient if sign_a^sign_b, negate remainder if sign_a) and selecting result; FIX->DONE.
REQ-021 Normal latency: out_valid first high WIDTH+2 cycles after the accept edge.
REQ-022 Divide by zero: IDLE->DONE directly; quotient all ones, remainder = din_a, dz=1, vout=0; out_valid 1 cycle after accept.
REQ-023 Reserved op: IDLE->DONE directly; dout=0, dz=1, vout=0.
REQ-024 Signed overflow (DIV with din_a=most-negative, din_b=-1): full latency, quotient = most-negative, vout=1; REM case gives 0, vout=0.
REQ-025 MUL vout=1 when high half of product nonzero; MULH vout=0; unsigned divides vout=0.
REQ-026 DONE: out_valid=1, dout/vout/dz stable; DONE->IDLE on out_ready; no new request accepted in the same cycle as out_ready (one IDLE cycle minimum between results).
REQ-027 flush in any state forces IDLE next cycle, out_valid low, result registers unchanged; flush wins over accept and over out_ready in the same cycle.
REQ-028 Operand inputs ignored outside the accept cycle.

Reset
REQ-029 reset_b low asynchronously forces state IDLE, counter 0, out_valid=0, dout=0, vout=0, dz=0; in_ready=1 from first cycle after release.
REQ-030 Reset mid-operation discards the operation; no out_valid results.

Structure
REQ-031 Opcode encodings and state encodings live in the shared CPU header/package alongside existing ALU opcodes.
REQ-032 One sub-module muldiv_step: combinational single iteration (add or subtract-compare) of width WIDTH+1, instantiated once.
REQ-033 No DSP inference; datapath is one WIDTH+1 adder plus 2*WIDTH shift register.

Verification (WIDTH=32)
REQ-034 MUL 0x0001_0000 * 0x0001_0000 -> dout 0, vout 1, out_valid at cycle 34; MULH same -> dout 0x1.
REQ-035 DIV 0xFFFF_FFF9 (-7) / 2 -> dout 0xFFFF_FFFD (-3); REM same -> 0xFFFF_FFFF (-1), vout 0.
REQ-036 DIVU 100 / 0 -> out_valid cycle 1, dout 0xFFFF_FFFF, dz 1; REMU 100/0 -> dout 100.
REQ-037 DIV 0x8000_0000 / 0xFFFF_FFFF -> dout 0x8000_0000, vout 1.
REQ-038 flush at RUN cycle 10, then immediate DIVU 9/3 -> only one out_valid, dout 3; out_ready held low 5 cycles -> dout stable, in_ready 0 throughout.
REQ-039 reset_b pulsed low mid-RUN -> outputs zero immediately, in_ready 1 after release, no spurious out_valid.
